// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI burst RAM slave: command encodings and FSM states.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4,
        ST_BURST_WR  = 3'd5,
        ST_BURST_RD  = 3'd6
    } state_t;

endpackage

// File: rtl/spram_sync.sv
// Single-port synchronous RAM: registered read, write enable, array never reset.
module spram_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_r;

    // Array write and registered read; rdata holds until the next read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/spi_ram_burst_slave.sv
// SPI slave (sampled on clk) with embedded RAM, auto-incrementing pointers and
// burst write/read streaming while ss_n stays low.
module spi_ram_burst_slave
    import spi_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ss_n,
    input  logic mosi,
    output logic miso,
    output logic frame_abort
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]  WORD_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    bit_cnt_r;
    logic [DATA_W-1:0]   rx_sh_r;
    logic [DATA_W-1:0]   tx_sh_r;
    logic [DATA_W-1:0]   prefetch_r;
    logic [ADDR_W-1:0]   wr_ptr_r, rd_ptr_r, waddr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                we_r, rd_first_r, rd_src_ram_r, pf_cap_r;
    logic                miso_r, abort_r;

    logic [DATA_W:0]     frame_s;
    logic [DATA_W-1:0]   word_s;
    logic [DATA_W-1:0]   tx_src_s;
    logic [1:0]          cmd_s;
    logic                frame_last_s, word_last_s, abort_s;
    logic                ram_we_s, ram_re_s;
    logic [ADDR_W-1:0]   ram_addr_s;
    logic [DATA_W-1:0]   ram_rdata_s;

    // cmd[1] has already been consumed by CHK_CMD, so only cmd[0] and payload are kept.
    assign frame_s      = {rx_sh_r, mosi};
    assign word_s       = frame_s[DATA_W-1:0];
    assign cmd_s        = {(state_r != ST_WRITE), frame_s[DATA_W]};
    assign frame_last_s = (bit_cnt_r == FRAME_LAST);
    assign word_last_s  = (bit_cnt_r == WORD_LAST);
    assign tx_src_s     = rd_src_ram_r ? ram_rdata_s : prefetch_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and mid-word abort detection.
    always_comb begin
        state_s = state_r;
        abort_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!ss_n) begin
                    state_s = ST_CHK_CMD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHK_CMD: begin
                if (ss_n) begin
                    state_s = ST_IDLE;
                end else if (mosi) begin
                    state_s = ST_READ_ADD;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                if (ss_n) begin
                    state_s = ST_IDLE;
                    abort_s = 1'b1;
                end else if ((state_r == ST_READ_ADD) && (bit_cnt_r == CNT_ONE)
                             && ({1'b1, mosi} == CMD_RD_DATA)) begin
                    state_s = ST_READ_DATA;
                end else if (frame_last_s) begin
                    case (cmd_s)
                        CMD_WR_DATA: state_s = ST_BURST_WR;
                        CMD_RD_DATA: state_s = ST_BURST_RD;
                        default:     state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = state_r;
                end
            end
            ST_BURST_WR: begin
                if (ss_n) begin
                    state_s = ST_IDLE;
                    abort_s = (bit_cnt_r != CNT_ZERO);
                end else begin
                    state_s = ST_BURST_WR;
                end
            end
            ST_BURST_RD: begin
                if (ss_n) begin
                    state_s = ST_IDLE;
                    abort_s = !rd_first_r && (bit_cnt_r != CNT_ZERO);
                end else begin
                    state_s = ST_BURST_RD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // RAM port: a pending write owns the port, otherwise it serves the read pointer.
    always_comb begin
        ram_we_s   = we_r && !rst;
        ram_re_s   = 1'b0;
        ram_addr_s = rd_ptr_r;
        if (we_r) begin
            ram_addr_s = waddr_r;
        end else begin
            ram_addr_s = rd_ptr_r;
        end
        if ((state_r == ST_BURST_RD) && !ss_n && !rst
            && (rd_first_r || (bit_cnt_r == CNT_ZERO))) begin
            ram_re_s = 1'b1;
        end else begin
            ram_re_s = 1'b0;
        end
    end

    // Datapath: shifters, bit counter, pointers, write staging and read prefetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r    <= '0;
            rx_sh_r      <= '0;
            tx_sh_r      <= '0;
            prefetch_r   <= '0;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            waddr_r      <= '0;
            wdata_r      <= '0;
            we_r         <= 1'b0;
            rd_first_r   <= 1'b0;
            rd_src_ram_r <= 1'b0;
            pf_cap_r     <= 1'b0;
            miso_r       <= 1'b0;
            abort_r      <= 1'b0;
        end else begin
            we_r       <= 1'b0;
            rd_first_r <= 1'b0;
            pf_cap_r   <= 1'b0;
            miso_r     <= 1'b0;
            abort_r    <= abort_s;
            if (pf_cap_r) begin
                prefetch_r <= ram_rdata_s;
            end
            case (state_r)
                ST_CHK_CMD: begin
                    bit_cnt_r <= '0;
                    rx_sh_r   <= '0;
                end
                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    if (!ss_n) begin
                        rx_sh_r   <= frame_s[DATA_W-1:0];
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        if (frame_last_s) begin
                            bit_cnt_r <= '0;
                            case (cmd_s)
                                CMD_WR_ADDR: wr_ptr_r <= word_s[ADDR_W-1:0];
                                CMD_WR_DATA: begin
                                    we_r     <= 1'b1;
                                    waddr_r  <= wr_ptr_r;
                                    wdata_r  <= word_s;
                                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                                end
                                CMD_RD_ADDR: rd_ptr_r <= word_s[ADDR_W-1:0];
                                CMD_RD_DATA: rd_first_r <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                end
                ST_BURST_WR: begin
                    if (!ss_n) begin
                        rx_sh_r <= frame_s[DATA_W-1:0];
                        if (word_last_s) begin
                            bit_cnt_r <= '0;
                            we_r      <= 1'b1;
                            waddr_r   <= wr_ptr_r;
                            wdata_r   <= word_s;
                            wr_ptr_r  <= wr_ptr_r + PTR_ONE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_BURST_RD: begin
                    if (!ss_n) begin
                        if (rd_first_r) begin
                            rd_ptr_r     <= rd_ptr_r + PTR_ONE;
                            rd_src_ram_r <= 1'b1;
                            bit_cnt_r    <= '0;
                        end else if (bit_cnt_r == CNT_ZERO) begin
                            // Word load doubles as the prefetch read of the following word.
                            miso_r       <= tx_src_s[DATA_W-1];
                            tx_sh_r      <= {tx_src_s[DATA_W-2:0], 1'b0};
                            rd_ptr_r     <= rd_ptr_r + PTR_ONE;
                            rd_src_ram_r <= 1'b0;
                            pf_cap_r     <= 1'b1;
                            bit_cnt_r    <= WORD_LAST;
                        end else begin
                            miso_r    <= tx_sh_r[DATA_W-1];
                            tx_sh_r   <= {tx_sh_r[DATA_W-2:0], 1'b0};
                            bit_cnt_r <= bit_cnt_r - CNT_ONE;
                        end
                    end
                end
                default: begin
                    bit_cnt_r <= '0;
                end
            endcase
        end
    end

    spram_sync #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .addr  (ram_addr_s),
        .wdata (wdata_r),
        .rdata (ram_rdata_s)
    );

    assign miso        = miso_r;
    assign frame_abort = abort_r;

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// Scoreboard bench for spi_ram_burst_slave: an 8/8 instance and a 16/4 instance
// share clk/rst; ss_n/mosi are routed to whichever instance is selected.
module tb_spi_ram_burst_slave;

    logic clk = 1'b0;
    logic rst, ss_n, mosi, use16;
    logic ss_n8_s, ss_n16_s;
    logic miso8, abort8, miso16, abort16;
    logic miso_s, abort_s;

    assign ss_n8_s  = use16 ? 1'b1 : ss_n;
    assign ss_n16_s = use16 ? ss_n : 1'b1;
    assign miso_s   = use16 ? miso16 : miso8;
    assign abort_s  = use16 ? abort16 : abort8;

    spi_ram_burst_slave #(.DATA_W(8), .ADDR_W(8)) dut8 (
        .clk(clk), .rst(rst), .ss_n(ss_n8_s), .mosi(mosi),
        .miso(miso8), .frame_abort(abort8)
    );

    spi_ram_burst_slave #(.DATA_W(16), .ADDR_W(4)) dut16 (
        .clk(clk), .rst(rst), .ss_n(ss_n16_s), .mosi(mosi),
        .miso(miso16), .frame_abort(abort16)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int dw, depth;
    int wptr [2];
    logic [15:0] model_mem [2][256];
    logic [15:0] exp_q [$];
    logic [15:0] wq [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        tick();
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = dw - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    // E0 (enter CHK_CMD), E1 (cmd[1] decides), then the frame cmd[1:0] + payload.
    task automatic send_frame(input logic [1:0] cmd, input logic [15:0] payload);
        ss_n = 1'b0;
        mosi = cmd[1];
        tick();
        tick();
        send_bit(cmd[1]);
        send_bit(cmd[0]);
        send_word(payload);
    endtask

    task automatic end_txn(input string tag);
        ss_n = 1'b1;
        mosi = 1'b0;
        tick();
        check_val({tag, "_no_abort"}, {31'd0, abort_s}, 32'd0);
        check_val({tag, "_miso_idle"}, {31'd0, miso_s}, 32'd0);
        tick();
    endtask

    task automatic select(input logic sel);
        use16 = sel;
        dw    = sel ? 16 : 8;
        depth = sel ? 16 : 256;
    endtask

    task automatic wr_addr(input int a);
        send_frame(2'b00, 16'(a));
        end_txn("wr_addr");
        wptr[use16] = a % depth;
    endtask

    // Writes every word of wq as one WR_DATA frame followed by burst words.
    task automatic wr_burst();
        for (int i = 0; i < wq.size(); i++) begin
            if (i == 0) send_frame(2'b01, wq[0]);
            else        send_word(wq[i]);
            model_mem[use16][wptr[use16]] = wq[i];
            wptr[use16] = (wptr[use16] + 1) % depth;
        end
        end_txn("wr_burst");
        wq.delete();
    endtask

    task automatic rd_stream(input logic set_addr, input int a, input int nwords);
        logic [15:0] got;
        logic [15:0] exp;
        if (set_addr) begin
            send_frame(2'b10, 16'(a));
            end_txn("rd_addr");
        end
        for (int k = 0; k < nwords; k++) exp_q.push_back(model_mem[use16][(a + k) % depth]);
        send_frame(2'b11, 16'($urandom));
        mosi = 1'b1;
        tick();
        check_val("rd_l1_miso_low", {31'd0, miso_s}, 32'd0);
        for (int k = 0; k < nwords; k++) begin
            got = '0;
            for (int b = 0; b < dw; b++) begin
                mosi = 1'($urandom);
                tick();
                got = {got[14:0], miso_s};
            end
            exp = exp_q.pop_front();
            check_val("rd_word", {16'd0, got}, {16'd0, exp});
        end
        end_txn("rd_data");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ss_n = 1'b1;
        mosi = 1'b0;
        select(1'b0);
        wptr[0] = 0;
        wptr[1] = 0;
        repeat (3) tick();
        check_val("reset_miso8", {31'd0, miso8}, 32'd0);
        check_val("reset_abort8", {31'd0, abort8}, 32'd0);
        check_val("reset_miso16", {31'd0, miso16}, 32'd0);
        rst = 1'b0;
        tick();

        // Separate address and data transactions.
        wr_addr(8'h0F);
        wq.push_back(16'h53);
        wr_burst();

        // Abort after 5 payload bits of WR_DATA 0x77.
        ss_n = 1'b0;
        tick();
        tick();
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 7; i > 2; i--) begin
            logic [7:0] v;
            v = 8'h77;
            send_bit(v[i]);
        end
        ss_n = 1'b1;
        tick();
        check_val("abort_pulse", {31'd0, abort_s}, 32'd1);
        tick();
        check_val("abort_one_cycle", {31'd0, abort_s}, 32'd0);

        // wr_ptr must still be 0x10 after the abort.
        wq.push_back(16'h5A);
        wr_burst();

        // Burst write with pointer wrap.
        wr_addr(8'hFE);
        wq.push_back(16'hA1);
        wq.push_back(16'hB2);
        wq.push_back(16'hC3);
        wr_burst();

        rd_stream(1'b1, 8'h0F, 2);
        rd_stream(1'b1, 8'hFE, 3);
        rd_stream(1'b1, 8'h10, 1);

        // Reset in the middle of a burst read.
        send_frame(2'b10, 16'hFF);
        end_txn("rd_addr_rst");
        send_frame(2'b11, 16'h00);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check_val("rst_mid_rd_miso", {31'd0, miso_s}, 32'd0);
        check_val("rst_mid_rd_abort", {31'd0, abort_s}, 32'd0);
        rst = 1'b0;
        ss_n = 1'b1;
        tick();
        tick();
        wptr[0] = 0;
        wptr[1] = 0;

        // Pointers back at 0, RAM contents kept.
        rd_stream(1'b0, 0, 1);
        wq.push_back(16'h3C);
        wr_burst();
        rd_stream(1'b1, 0, 2);

        // 16-bit instance: 17-word burst from address 0 wraps onto address 0.
        select(1'b1);
        wr_addr(0);
        for (int i = 0; i < 17; i++) wq.push_back(16'hA000 + 16'(i));
        wr_burst();
        rd_stream(1'b1, 15, 3);
        rd_stream(1'b1, 0, 1);

        check_val("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_ram_burst_slave.md
# spi_ram_burst_slave

Parametrised SPI slave with an embedded single-port RAM, sampled synchronously to the system clock. It is the next generation of the 10-bit-frame SPI/RAM wrapper, generalised in data width and depth. It adds auto-incrementing address pointers and burst write/read: a slave select held low streams consecutive words without re-sending command bits. It sits between an external SPI master and on-chip configuration/data storage.

## Interface
- `DATA_W`, 8, RAM word width and frame payload width
- `ADDR_W`, 8, address width; `MEM_DEPTH` = 2**`ADDR_W`; `ADDR_W` <= `DATA_W` is required
- `clk` in 1: single system clock; every action happens on the rising edge
- `rst` in 1: reset, synchronous and active-high
- `ss_n` in 1: slave select, active-low; high ends or aborts any transaction
- `mosi` in 1: serial data in, MSB first, one bit per `clk`
- `miso` out 1: serial data out, MSB first, one bit per `clk`
- `frame_abort` out 1: one-cycle pulse when `ss_n` rises mid-word

## Operation
- Commands (2 bits):
  - 00 WR_ADDR: set `wr_ptr`
  - 01 WR_DATA: write the word, then burst
  - 10 RD_ADDR: set `rd_ptr`
  - 11 RD_DATA: stream RAM words out on `miso`
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, BURST_WR, BURST_RD.
  - IDLE→CHK_CMD when `ss_n`=0.
  - In CHK_CMD, `mosi` (must equal cmd[1]) selects WRITE (0) or a READ state (1). READ_ADD vs READ_DATA is resolved from cmd[0] once the frame shifts in; a read-address frame only updates `rd_ptr`.
  - Any state→IDLE when `ss_n`=1.
- Frame: after CHK_CMD, 2+`DATA_W` bits shifted in MSB first: cmd[1:0], then payload.
- Address payload: only the low `ADDR_W` bits are used; upper bits are ignored.
- WR_DATA: payload written to RAM[`wr_ptr`], then `wr_ptr` increments.
  - If `ss_n` stays low, the FSM enters BURST_WR.
  - Each further `DATA_W` bits (no command bits) form one word, written to RAM[`wr_ptr`], then `wr_ptr` increments.
- RD_DATA: payload bits are don't-care. RAM[`rd_ptr`] is fetched, `rd_ptr` increments, then BURST_RD streams words back to back.
  - The next word is prefetched during the current word, so there is no gap between words.
  - `mosi` is ignored in BURST_RD.
- Pointer wrap: `MEM_DEPTH`-1 + 1 → 0, for both pointers.
- Abort: `ss_n`=1 before a word completes.
  - The partial word is discarded: no RAM write, no pointer change.
  - `frame_abort` pulses for 1 cycle.
  - Return to IDLE.
  - `ss_n`=1 exactly at a word boundary is a normal end, not an abort. Raising it during BURST_RD after a complete word is also a normal end.
- Reset:
  - State IDLE; `wr_ptr` = `rd_ptr` = 0; shift registers 0; `miso`=0; `frame_abort`=0.
  - RAM contents are not cleared.
  - Reset mid-transaction takes effect at that edge; no write is committed that cycle.

## Timing
- Edge naming: E0 = first edge with `ss_n`=0 (enter CHK_CMD); E1 = enter WRITE/READ; frame bit k is sampled at edge E2+k.
- Write commit: RAM write happens at the edge after the last payload bit is sampled.
- Burst word n (n>=1): its last bit is sampled at E2+(2+`DATA_W`)·1+n·`DATA_W`-1; its write follows at the next edge.
- Read latency, with L = edge sampling the last RD_DATA frame bit:
  - L+1: RAM read issued.
  - L+2: data loaded into the tx shifter; `miso` = word MSB.
  - Each following bit changes after each subsequent edge.
- Bursting reads: word n+1 MSB follows word n LSB in the very next cycle.
- `miso` is 0 whenever not in BURST_RD.
- `frame_abort`: asserted the cycle after the edge that samples `ss_n`=1 mid-word.

## Structure
- Package `spi_ram_pkg`: command encodings (`CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA`) and the FSM state enum.
- Sub-module `spram_sync`: single-port RAM, parameters `DATA_W` and `ADDR_W`, 1-cycle registered read, write enable, no reset of the array.
- Top level holds the FSM, rx/tx shifters, bit counter ($clog2(2+`DATA_W`) bits), the pointers and the prefetch register.

## Test plan
- WR_ADDR 0x0F, then WR_DATA 0x53 (separate transactions) → RAM[0x0F]=0x53; `wr_ptr`=0x10.
- Burst write: WR_ADDR 0xFE; WR_DATA 0xA1, then words 0xB2, 0xC3 with `ss_n` held low → RAM[0xFE]=0xA1, RAM[0xFF]=0xB2, RAM[0x00]=0xC3 (wrap).
- RD_ADDR 0x0F; RD_DATA with `ss_n` held for 16 further cycles → `miso` carries 0x53, then RAM[0x10], MSB first starting at L+2, with no gap between words.
- Abort: WR_DATA 0x77 with `ss_n` raised after 5 payload bits → `frame_abort` pulses once; RAM and `wr_ptr` unchanged; next transaction decodes normally.
- `rst` asserted mid-burst-read → next cycle `miso`=0, pointers 0, state IDLE; RAM contents intact.
- `DATA_W`=16, `ADDR_W`=4: burst write of 17 words from address 0 → the last word overwrites address 0.
